pong_game_ctrl: RTL and testbench



---
 rtl/pong_pkg.sv | 27 ++
 rtl/pong_game_ctrl_if.sv | 28 ++
 rtl/rise_detect.sv | 27 ++
 rtl/pong_game_ctrl.sv | 170 +++++++++++++++++
 tb/tb_pong_game_ctrl.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/pong_pkg.sv
// pong_pkg: shared types and constants for the pong datapath.
//   game_state_t  : match sequencer state encoding (also exported as state_code)
//   X/Y_RESOLUTION: playfield size used by the ball/paddle datapath
//   *_DEF         : default match parameters
//   WINNER_*      : winner output encoding
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SERVE     = 3'd1,
    ST_PLAY      = 3'd2,
    ST_PAUSED    = 3'd3,
    ST_POINT     = 3'd4,
    ST_GAME_OVER = 3'd5
  } game_state_t;

  localparam int X_RESOLUTION = 800;
  localparam int Y_RESOLUTION = 600;

  localparam int WIN_SCORE_DEF   = 7;
  localparam int SERVE_DELAY_DEF = 50_000_000;

  localparam logic [1:0] WINNER_NONE = 2'b00;
  localparam logic [1:0] WINNER_P1   = 2'b01;
  localparam logic [1:0] WINNER_P2   = 2'b10;

endpackage

// File: rtl/pong_game_ctrl_if.sv
// pong_game_ctrl_if: board buttons, ball-tracker handshake and score/display
// outputs of the match sequencer.
//   master : button/ball-tracker side (drives buttons and point flags)
//   slave  : the match sequencer (drives game_on, ball_rst_n, scores, winner, state_code)
interface pong_game_ctrl_if #(
  parameter int SCORE_W = 4
);
  logic               start_btn;
  logic               pause_btn;
  logic               player1_point;
  logic               player2_point;
  logic               game_on;
  logic               ball_rst_n;
  logic [SCORE_W-1:0] score1;
  logic [SCORE_W-1:0] score2;
  logic [1:0]         winner;
  logic [2:0]         state_code;

  modport master (
    output start_btn, pause_btn, player1_point, player2_point,
    input  game_on, ball_rst_n, score1, score2, winner, state_code
  );

  modport slave (
    input  start_btn, pause_btn, player1_point, player2_point,
    output game_on, ball_rst_n, score1, score2, winner, state_code
  );
endinterface

// File: rtl/rise_detect.sv
// rise_detect: single-cycle pulse on a 0->1 transition of a synchronous level.
//   clk   : clock
//   reset : asynchronous active-low reset (clears the history bit)
//   in    : synchronous level input
//   pulse : high for the one cycle where in is 1 and was 0 on the previous edge
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic pulse
);

  logic in_q_r;

  // one-cycle history of the input level
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_q_r <= 1'b0;
    end else begin
      in_q_r <= in;
    end
  end

  // holding the input high yields exactly one pulse
  assign pulse = in & ~in_q_r;

endmodule

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: match sequencer for the pong datapath (serve timing,
// scoring, pause, game-over).
//   clk   : 50 MHz master clock
//   reset : asynchronous active-low reset
//   bus   : slave side of pong_game_ctrl_if
//           in : start_btn, pause_btn (levels, rising edge used),
//                player1_point, player2_point (ball tracker flags)
//           out: game_on, ball_rst_n, score1, score2, winner, state_code
// All outputs are registered and reflect the state entered on that edge.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE   = WIN_SCORE_DEF,
  parameter int SERVE_DELAY = SERVE_DELAY_DEF,
  parameter int SCORE_W     = 4
) (
  input  logic            clk,
  input  logic            reset,
  pong_game_ctrl_if.slave bus
);

  localparam int                 CNT_W      = $clog2(SERVE_DELAY + 1);
  localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_DELAY - 1);
  localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);

  game_state_t        state_r,      state_nxt_s;
  logic [CNT_W-1:0]   cnt_r,        cnt_nxt_s;
  logic [SCORE_W-1:0] score1_r,     score1_nxt_s;
  logic [SCORE_W-1:0] score2_r,     score2_nxt_s;
  logic [1:0]         winner_r,     winner_nxt_s;
  logic               game_on_r,    game_on_nxt_s;
  logic               ball_rst_n_r, ball_rst_n_nxt_s;
  logic               start_rise_s;
  logic               pause_rise_s;
  logic               p1_s;
  logic               p2_s;

  assign p1_s = bus.player1_point;
  assign p2_s = bus.player2_point;

  rise_detect u_start_rise (
    .clk   (clk),
    .reset (reset),
    .in    (bus.start_btn),
    .pulse (start_rise_s)
  );

  rise_detect u_pause_rise (
    .clk   (clk),
    .reset (reset),
    .in    (bus.pause_btn),
    .pulse (pause_rise_s)
  );

  // next-state, scoring and output decode
  always_comb begin
    state_nxt_s  = state_r;
    cnt_nxt_s    = cnt_r;
    score1_nxt_s = score1_r;
    score2_nxt_s = score2_r;
    winner_nxt_s = winner_r;

    case (state_r)
      ST_IDLE, ST_GAME_OVER: begin
        if (start_rise_s) begin
          score1_nxt_s = '0;
          score2_nxt_s = '0;
          winner_nxt_s = WINNER_NONE;
          cnt_nxt_s    = '0;
          state_nxt_s  = ST_SERVE;
        end else begin
          state_nxt_s  = state_r;
        end
      end

      ST_SERVE: begin
        // counter 0..SERVE_DELAY-1, so SERVE lasts exactly SERVE_DELAY cycles
        if (cnt_r == SERVE_LAST) begin
          state_nxt_s = ST_PLAY;
        end else begin
          cnt_nxt_s   = cnt_r + CNT_W'(1);
        end
      end

      ST_PLAY: begin
        // point flags take priority over a simultaneous pause press;
        // both flags together is a re-serve with no score change
        if (p1_s && p2_s) begin
          state_nxt_s = ST_POINT;
        end else if (p1_s) begin
          if (score1_r < WIN_VAL) begin
            score1_nxt_s = score1_r + SCORE_W'(1);
          end else begin
            score1_nxt_s = score1_r;
          end
          state_nxt_s = ST_POINT;
        end else if (p2_s) begin
          if (score2_r < WIN_VAL) begin
            score2_nxt_s = score2_r + SCORE_W'(1);
          end else begin
            score2_nxt_s = score2_r;
          end
          state_nxt_s = ST_POINT;
        end else if (pause_rise_s) begin
          state_nxt_s = ST_PAUSED;
        end else begin
          state_nxt_s = ST_PLAY;
        end
      end

      ST_PAUSED: begin
        if (pause_rise_s) begin
          state_nxt_s = ST_PLAY;
        end else begin
          state_nxt_s = ST_PAUSED;
        end
      end

      ST_POINT: begin
        if (score1_r == WIN_VAL) begin
          winner_nxt_s = WINNER_P1;
          state_nxt_s  = ST_GAME_OVER;
        end else if (score2_r == WIN_VAL) begin
          winner_nxt_s = WINNER_P2;
          state_nxt_s  = ST_GAME_OVER;
        end else begin
          cnt_nxt_s    = '0;
          state_nxt_s  = ST_SERVE;
        end
      end

      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase

    // outputs follow the state being entered so they register on the same edge
    game_on_nxt_s    = (state_nxt_s == ST_PLAY);
    ball_rst_n_nxt_s = (state_nxt_s == ST_PLAY) || (state_nxt_s == ST_PAUSED);
  end

  // state, counter, score and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      cnt_r        <= '0;
      score1_r     <= '0;
      score2_r     <= '0;
      winner_r     <= WINNER_NONE;
      game_on_r    <= 1'b0;
      ball_rst_n_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      cnt_r        <= cnt_nxt_s;
      score1_r     <= score1_nxt_s;
      score2_r     <= score2_nxt_s;
      winner_r     <= winner_nxt_s;
      game_on_r    <= game_on_nxt_s;
      ball_rst_n_r <= ball_rst_n_nxt_s;
    end
  end

  assign bus.game_on    = game_on_r;
  assign bus.ball_rst_n = ball_rst_n_r;
  assign bus.score1     = score1_r;
  assign bus.score2     = score2_r;
  assign bus.winner     = winner_r;
  assign bus.state_code = state_r;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl: scoreboard bench for pong_game_ctrl with WIN_SCORE=3,
// SERVE_DELAY=4. Each driven cycle pushes the expected post-edge outputs to
// a queue; after the edge the entry is popped and compared.
module tb_pong_game_ctrl;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SERVE = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_PAUSE = 3'd3;
  localparam logic [2:0] S_POINT = 3'd4;
  localparam logic [2:0] S_OVER  = 3'd5;

  typedef struct packed {
    logic [2:0] st;
    logic       go;
    logic       brn;
    logic [3:0] s1;
    logic [3:0] s2;
    logic [1:0] w;
  } exp_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   step;
  exp_t sb[$];

  pong_game_ctrl_if #(.SCORE_W(4)) bus ();

  pong_game_ctrl #(
    .WIN_SCORE   (3),
    .SERVE_DELAY (4),
    .SCORE_W     (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // expected outputs for a state: game_on only in PLAY, ball released in PLAY/PAUSED
  function automatic exp_t ex(input logic [2:0] st, input logic [3:0] s1,
                              input logic [3:0] s2, input logic [1:0] w);
    exp_t e;
    e.st  = st;
    e.go  = (st == S_PLAY);
    e.brn = (st == S_PLAY) || (st == S_PAUSE);
    e.s1  = s1;
    e.s2  = s2;
    e.w   = w;
    return e;
  endfunction

  task automatic compare_out(input exp_t e);
    chk($sformatf("state#%0d", step),  {29'd0, bus.state_code}, {29'd0, e.st});
    chk($sformatf("game_on#%0d", step), {31'd0, bus.game_on},   {31'd0, e.go});
    chk($sformatf("ball_rst_n#%0d", step), {31'd0, bus.ball_rst_n}, {31'd0, e.brn});
    chk($sformatf("score1#%0d", step), {28'd0, bus.score1}, {28'd0, e.s1});
    chk($sformatf("score2#%0d", step), {28'd0, bus.score2}, {28'd0, e.s2});
    chk($sformatf("winner#%0d", step), {30'd0, bus.winner}, {30'd0, e.w});
  endtask

  // drive one cycle of inputs, queue the expectation, pop and compare after the edge
  task automatic cyc(input logic st, input logic pa, input logic p1, input logic p2,
                     input exp_t e);
    exp_t got_e;
    bus.start_btn     = st;
    bus.pause_btn     = pa;
    bus.player1_point = p1;
    bus.player2_point = p2;
    sb.push_back(e);
    @(posedge clk);
    #1;
    step++;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      got_e = sb.pop_front();
      compare_out(got_e);
    end
  endtask

  // remaining SERVE cycles after entry, then PLAY
  task automatic serve_wait(input logic [3:0] s1, input logic [3:0] s2);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, ex(S_SERVE, s1, s2, 2'b00));
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, ex(S_PLAY, s1, s2, 2'b00));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    step  = 0;
    reset = 1'b0;
    bus.start_btn     = 1'b0;
    bus.pause_btn     = 1'b0;
    bus.player1_point = 1'b0;
    bus.player2_point = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    compare_out(ex(S_IDLE, 4'd0, 4'd0, 2'b00));
    reset = 1'b1;

    // 1: idle, start, SERVE x4, PLAY
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, ex(S_IDLE, 4'd0, 4'd0, 2'b00));
    cyc(1'b1, 1'b0, 1'b0, 1'b0, ex(S_SERVE, 4'd0, 4'd0, 2'b00));
    serve_wait(4'd0, 4'd0);

    // start edge in PLAY is ignored
    cyc(1'b0, 1'b0, 1'b0, 1'b0, ex(S_PLAY, 4'd0, 4'd0, 2'b00));
    cyc(1'b1, 1'b0, 1'b0, 1'b0, ex(S_PLAY, 4'd0, 4'd0, 2'b00));

    // 2: player1 flag held through POINT and SERVE scores once
    cyc(1'b0, 1'b0, 1'b1, 1'b0, ex(S_POINT, 4'd1, 4'd0, 2'b00));
    cyc(1'b0, 1'b0, 1'b1, 1'b0, ex(S_SERVE, 4'd1, 4'd0, 2'b00));
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, ex(S_SERVE, 4'd1, 4'd0, 2'b00));
    cyc(1'b0, 1'b0, 1'b0, 1'b0, ex(S_PLAY, 4'd1, 4'd0, 2'b00));

    // 3: three player2 points -> GAME_OVER, winner 10
    for (int k = 1; k <= 2; k++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1, ex(S_POINT, 4'd1, 4'(k), 2'b00));
      cyc(1'b0, 1'b0, 1'b0, 1'b1, ex(S_SERVE, 4'd1, 4'(k), 2'b00));
      serve_wait(4'd1, 4'(k));
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b1, ex(S_POINT, 4'd1, 4'd3, 2'b00));
    cyc(1'b0, 1'b0, 1'b0, 1'b1, ex(S_OVER, 4'd1, 4'd3, 2'b10));
    cyc(1'b0, 1'b0, 1'b1, 1'b1, ex(S_OVER, 4'd1, 4'd3, 2'b10));
    cyc(1'b0, 1'b1, 1'b0, 1'b1, ex(S_OVER, 4'd1, 4'd3, 2'b10));
    cyc(1'b1, 1'b0, 1'b0, 1'b0, ex(S_SERVE, 4'd0, 4'd0, 2'b00));
    serve_wait(4'd0, 4'd0);

    // 4: both flags -> re-serve; pause with a point -> POINT wins
    cyc(1'b0, 1'b0, 1'b1, 1'b1, ex(S_POINT, 4'd0, 4'd0, 2'b00));
    cyc(1'b0, 1'b0, 1'b1, 1'b1, ex(S_SERVE, 4'd0, 4'd0, 2'b00));
    serve_wait(4'd0, 4'd0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, ex(S_POINT, 4'd1, 4'd0, 2'b00));
    cyc(1'b0, 1'b1, 1'b0, 1'b0, ex(S_SERVE, 4'd1, 4'd0, 2'b00));
    serve_wait(4'd1, 4'd0);

    // 5: pause, flags ignored, held pause toggles once
    cyc(1'b0, 1'b1, 1'b0, 1'b0, ex(S_PAUSE, 4'd1, 4'd0, 2'b00));
    cyc(1'b0, 1'b1, 1'b1, 1'b0, ex(S_PAUSE, 4'd1, 4'd0, 2'b00));
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1, ex(S_PAUSE, 4'd1, 4'd0, 2'b00));
    cyc(1'b0, 1'b0, 1'b0, 1'b0, ex(S_PAUSE, 4'd1, 4'd0, 2'b00));
    cyc(1'b0, 1'b1, 1'b0, 1'b0, ex(S_PLAY, 4'd1, 4'd0, 2'b00));
    cyc(1'b0, 1'b1, 1'b0, 1'b0, ex(S_PLAY, 4'd1, 4'd0, 2'b00));
    cyc(1'b0, 1'b0, 1'b0, 1'b0, ex(S_PLAY, 4'd1, 4'd0, 2'b00));

    // 6: reset mid-SERVE with score1=2
    cyc(1'b0, 1'b0, 1'b1, 1'b0, ex(S_POINT, 4'd2, 4'd0, 2'b00));
    cyc(1'b0, 1'b0, 1'b0, 1'b0, ex(S_SERVE, 4'd2, 4'd0, 2'b00));
    cyc(1'b0, 1'b0, 1'b0, 1'b0, ex(S_SERVE, 4'd2, 4'd0, 2'b00));
    #2;
    reset = 1'b0;
    #1;
    compare_out(ex(S_IDLE, 4'd0, 4'd0, 2'b00));
    bus.start_btn = 1'b1;
    @(posedge clk);
    #1;
    bus.start_btn = 1'b0;
    @(posedge clk);
    #1;
    compare_out(ex(S_IDLE, 4'd0, 4'd0, 2'b00));
    reset = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, ex(S_IDLE, 4'd0, 4'd0, 2'b00));
    cyc(1'b0, 1'b0, 1'b0, 1'b0, ex(S_IDLE, 4'd0, 4'd0, 2'b00));
    cyc(1'b1, 1'b0, 1'b0, 1'b0, ex(S_SERVE, 4'd0, 4'd0, 2'b00));
    serve_wait(4'd0, 4'd0);

    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
